// File: rtl/accel_i2c_sequencer.sv
// Accelerometer I2C command sequencer: writes the init table, then polls X/Y/Z.
// Ports: clk/reset, cmd_* to byte engine, eng_* from engine, accel_*/status out.
module accel_i2c_sequencer #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h53,
    parameter int         POLL_CYCLES = 500,
    parameter int         MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [7:0]  cmd_data,
    output logic        cmd_nack,
    input  logic        eng_done,
    input  logic [7:0]  eng_rx,
    input  logic        eng_ack_n,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        sample_valid,
    output logic        init_done,
    output logic        err,
    output logic [3:0]  state_dbg
);

    localparam logic [1:0]  OP_START = 2'b00;
    localparam logic [1:0]  OP_STOP  = 2'b01;
    localparam logic [1:0]  OP_WRITE = 2'b10;
    localparam logic [1:0]  OP_READ  = 2'b11;
    localparam logic [31:0] LP_POLL_LAST = 32'(POLL_CYCLES - 1);
    localparam logic [7:0]  LP_MAX_RETRY = 8'(MAX_RETRY);

    typedef enum logic [3:0] {
        INIT_ST, INIT_AW, INIT_REG, INIT_VAL, INIT_SP, WAIT,
        RD_ST, RD_AW, RD_REG, RD_RS, RD_AR, RD_BYTE, RD_SP,
        PUBLISH, ABORT_SP, FATAL
    } state_t;

    state_t       r_state;
    logic [2:0]   r_idx;
    logic [2:0]   r_byte;
    logic [7:0]   r_retry;
    logic [31:0]  r_poll;
    logic         r_busy;
    logic         r_abort_rd;
    // Bytes shift in from the top, so after six reads X0 sits in [7:0].
    logic [47:0]  r_stage;

    logic [7:0]   w_reg;
    logic [7:0]   w_val;
    logic         w_issue;
    logic [1:0]   w_op;
    logic [7:0]   w_data;
    logic         w_nack;
    logic         w_done;

    assign state_dbg = r_state;
    // A done pulse only counts while a command is actually outstanding.
    assign w_done = r_busy & eng_done;

    always_comb begin
        w_reg = 8'h00;
        w_val = 8'h00;
        case (r_idx)
            3'd0: begin w_reg = 8'h31; w_val = 8'h0B; end
            3'd1: begin w_reg = 8'h2C; w_val = 8'h0B; end
            3'd2: begin w_reg = 8'h24; w_val = 8'h04; end
            3'd3: begin w_reg = 8'h25; w_val = 8'h02; end
            3'd4: begin w_reg = 8'h26; w_val = 8'h02; end
            3'd5: begin w_reg = 8'h27; w_val = 8'hFF; end
            3'd6: begin w_reg = 8'h2D; w_val = 8'h00; end
            default: begin w_reg = 8'h2D; w_val = 8'h08; end
        endcase
    end

    // Command belonging to the current state; also tells which op is in flight.
    always_comb begin
        w_issue = 1'b1;
        w_op    = OP_START;
        w_data  = 8'h00;
        w_nack  = 1'b0;
        case (r_state)
            INIT_ST, RD_ST, RD_RS: w_op = OP_START;
            INIT_AW, RD_AW: begin
                w_op   = OP_WRITE;
                w_data = {SLAVE_ADDR, 1'b0};
            end
            INIT_REG: begin w_op = OP_WRITE; w_data = w_reg; end
            INIT_VAL: begin w_op = OP_WRITE; w_data = w_val; end
            RD_REG:   begin w_op = OP_WRITE; w_data = 8'h32; end
            RD_AR: begin
                w_op   = OP_WRITE;
                w_data = {SLAVE_ADDR, 1'b1};
            end
            RD_BYTE: begin
                w_op   = OP_READ;
                w_nack = (r_byte == 3'd5);
            end
            INIT_SP, RD_SP, ABORT_SP: w_op = OP_STOP;
            default: w_issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= INIT_ST;
            r_idx        <= 3'd0;
            r_byte       <= 3'd0;
            r_retry      <= 8'd0;
            r_poll       <= 32'd0;
            r_busy       <= 1'b0;
            r_abort_rd   <= 1'b0;
            r_stage      <= 48'd0;
            cmd_valid    <= 1'b0;
            cmd_op       <= OP_START;
            cmd_data     <= 8'h00;
            cmd_nack     <= 1'b0;
            accel_x      <= 16'd0;
            accel_y      <= 16'd0;
            accel_z      <= 16'd0;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
            err          <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
                r_busy    <= 1'b1;
            end else if (w_issue && !cmd_valid && !r_busy) begin
                cmd_valid <= 1'b1;
                cmd_op    <= w_op;
                cmd_data  <= w_data;
                cmd_nack  <= w_nack;
            end
            if (w_done) begin
                r_busy <= 1'b0;
            end

            case (r_state)
                WAIT: begin
                    if (r_poll == LP_POLL_LAST) begin
                        r_poll    <= 32'd0;
                        r_byte    <= 3'd0;
                        r_state   <= RD_ST;
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_START;
                        cmd_data  <= 8'h00;
                        cmd_nack  <= 1'b0;
                    end else begin
                        r_poll <= r_poll + 32'd1;
                    end
                end
                PUBLISH: begin
                    r_poll  <= 32'd0;
                    r_state <= WAIT;
                end
                FATAL: begin
                    err <= 1'b1;
                end
                default: begin
                    if (w_done) begin
                        if (w_op == OP_WRITE && eng_ack_n) begin
                            r_retry    <= r_retry + 8'd1;
                            r_abort_rd <= (r_state == RD_AW) ||
                                          (r_state == RD_REG) ||
                                          (r_state == RD_AR);
                            r_state    <= ABORT_SP;
                        end else begin
                            case (r_state)
                                INIT_ST:  r_state <= INIT_AW;
                                INIT_AW:  r_state <= INIT_REG;
                                INIT_REG: r_state <= INIT_VAL;
                                INIT_VAL: r_state <= INIT_SP;
                                INIT_SP: begin
                                    r_retry <= 8'd0;
                                    if (r_idx == 3'd7) begin
                                        init_done <= 1'b1;
                                        r_poll    <= 32'd0;
                                        r_state   <= WAIT;
                                    end else begin
                                        r_idx   <= r_idx + 3'd1;
                                        r_state <= INIT_ST;
                                    end
                                end
                                RD_ST:  r_state <= RD_AW;
                                RD_AW:  r_state <= RD_REG;
                                RD_REG: r_state <= RD_RS;
                                RD_RS:  r_state <= RD_AR;
                                RD_AR:  r_state <= RD_BYTE;
                                RD_BYTE: begin
                                    r_stage <= {eng_rx, r_stage[47:8]};
                                    if (r_byte == 3'd5) begin
                                        r_byte  <= 3'd0;
                                        r_state <= RD_SP;
                                    end else begin
                                        r_byte <= r_byte + 3'd1;
                                    end
                                end
                                RD_SP: begin
                                    r_retry      <= 8'd0;
                                    accel_x      <= r_stage[15:0];
                                    accel_y      <= r_stage[31:16];
                                    accel_z      <= r_stage[47:32];
                                    sample_valid <= 1'b1;
                                    r_state      <= PUBLISH;
                                end
                                ABORT_SP: begin
                                    r_byte <= 3'd0;
                                    if (r_retry >= LP_MAX_RETRY) begin
                                        err     <= 1'b1;
                                        r_state <= FATAL;
                                    end else if (r_abort_rd) begin
                                        r_state <= RD_ST;
                                    end else begin
                                        r_state <= INIT_ST;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_i2c_sequencer.sv
// Bench for accel_i2c_sequencer: engine model plus command scoreboard.
// Covers init order, sample reads, stalls, NACK retry, fatal error, reset abort.
module tb_accel_i2c_sequencer;

    localparam int POLL = 20;
    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        cmd_nack;
    logic        eng_done = 1'b0;
    logic [7:0]  eng_rx = 8'h00;
    logic        eng_ack_n = 1'b0;
    logic [15:0] accel_x;
    logic [15:0] accel_y;
    logic [15:0] accel_z;
    logic        sample_valid;
    logic        init_done;
    logic        err;
    logic [3:0]  state_dbg;

    always #5 clk = ~clk;

    accel_i2c_sequencer #(
        .SLAVE_ADDR(7'h53),
        .POLL_CYCLES(POLL),
        .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_data(cmd_data),
        .cmd_nack(cmd_nack),
        .eng_done(eng_done),
        .eng_rx(eng_rx),
        .eng_ack_n(eng_ack_n),
        .accel_x(accel_x),
        .accel_y(accel_y),
        .accel_z(accel_z),
        .sample_valid(sample_valid),
        .init_done(init_done),
        .err(err),
        .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] data;
        logic       nack;
    } cmd_t;

    typedef struct {
        logic [7:0] rg;
        logic [7:0] val;
    } init_t;

    typedef struct {
        int              rdy;
        logic [5:0][7:0] rx;
        logic [15:0]     ex;
        logic [15:0]     ey;
        logic [15:0]     ez;
    } rdvec_t;

    cmd_t       sb_q[$];
    logic [7:0] rx_q[$];
    init_t      itab[8];
    rdvec_t     rv[3];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] d,
                            input logic n);
        cmd_t c;
        c.op = op;
        c.data = d;
        c.nack = n;
        sb_q.push_back(c);
    endtask

    task automatic push_write(input int k);
        push_cmd(2'b00, 8'h00, 1'b0);
        push_cmd(2'b10, 8'hA6, 1'b0);
        push_cmd(2'b10, itab[k].rg, 1'b0);
        push_cmd(2'b10, itab[k].val, 1'b0);
        push_cmd(2'b01, 8'h00, 1'b0);
    endtask

    task automatic push_read();
        push_cmd(2'b00, 8'h00, 1'b0);
        push_cmd(2'b10, 8'hA6, 1'b0);
        push_cmd(2'b10, 8'h32, 1'b0);
        push_cmd(2'b00, 8'h00, 1'b0);
        push_cmd(2'b10, 8'hA7, 1'b0);
        for (int i = 0; i < 5; i++) push_cmd(2'b11, 8'h00, 1'b0);
        push_cmd(2'b11, 8'h00, 1'b1);
        push_cmd(2'b01, 8'h00, 1'b0);
    endtask

    // Engine model knobs and state.
    int   rdy_delay = 0;
    bit   nack_all = 0;
    int   nack_on = -1;
    bit   sb_en = 1;
    int   e_acc = 0;
    int   e_rd = 0;
    bit   e_busy = 0;
    bit   e_hold = 0;
    bit   e_unstable = 0;
    bit   e_viol = 0;
    int   e_wait = 0;
    int   e_lat = 0;
    int   e_idx = 0;
    cmd_t e_cmd;
    cmd_t e_held;
    cmd_t e_exp;

    always @(negedge clk) begin
        if (!reset) begin
            e_busy = 0;
            e_hold = 0;
            e_viol = 0;
            cmd_ready = 1'b0;
            eng_done = 1'b0;
            eng_ack_n = 1'b0;
        end else begin
            eng_done = 1'b0;
            eng_ack_n = 1'b0;
            cmd_ready = 1'b0;
            if (e_busy) begin
                if (cmd_valid) e_viol = 1;
                e_lat--;
                if (e_lat == 0) begin
                    e_busy = 0;
                    eng_done = 1'b1;
                    if (e_cmd.op == 2'b10)
                        eng_ack_n = nack_all || (e_idx == nack_on);
                    if (e_cmd.op == 2'b11) begin
                        if (rx_q.size() > 0) eng_rx = rx_q.pop_front();
                        else eng_rx = 8'h00;
                    end
                    chk("one_outstanding", 32'(e_viol), 32'd0);
                    e_viol = 0;
                end
            end else if (cmd_valid) begin
                if (!e_hold) begin
                    e_hold = 1;
                    e_held = {cmd_op, cmd_data, cmd_nack};
                    e_wait = rdy_delay;
                    e_unstable = 0;
                end else if ({cmd_op, cmd_data, cmd_nack} !== e_held) begin
                    e_unstable = 1;
                end
                if (e_wait == 0) begin
                    cmd_ready = 1'b1;
                    e_busy = 1;
                    e_lat = 3;
                    e_hold = 0;
                    e_cmd = {cmd_op, cmd_data, cmd_nack};
                    e_idx = e_acc;
                    e_acc++;
                    if (e_cmd.op == 2'b11) e_rd++;
                    if (rdy_delay > 0)
                        chk("cmd_stable", 32'(e_unstable), 32'd0);
                    if (sb_en) begin
                        if (sb_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_cmd actual=%h required=none",
                                     e_cmd);
                        end else begin
                            e_exp = sb_q.pop_front();
                            chk($sformatf("cmd%0d", e_idx), 32'(e_cmd),
                                32'(e_exp));
                        end
                    end
                end else begin
                    e_wait--;
                end
            end
        end
    end

    int sv_cnt = 0;
    int wrun = 0;
    int last_wait = 0;

    always @(negedge clk) begin
        if (sample_valid === 1'b1) sv_cnt++;
        if (state_dbg == 4'd5) begin
            wrun++;
        end else if (wrun > 0) begin
            last_wait = wrun;
            wrun = 0;
        end
    end

    initial begin
        int s0;
        int r0;
        int a0;
        bit cv;

        itab[0] = '{8'h31, 8'h0B};
        itab[1] = '{8'h2C, 8'h0B};
        itab[2] = '{8'h24, 8'h04};
        itab[3] = '{8'h25, 8'h02};
        itab[4] = '{8'h26, 8'h02};
        itab[5] = '{8'h27, 8'hFF};
        itab[6] = '{8'h2D, 8'h00};
        itab[7] = '{8'h2D, 8'h08};

        rv[0].rdy = 0;
        rv[0].rx = {8'h03, 8'h30, 8'h02, 8'h20, 8'h01, 8'h10};
        rv[0].ex = 16'h0110;
        rv[0].ey = 16'h0220;
        rv[0].ez = 16'h0330;
        rv[1].rdy = 5;
        rv[1].rx = {8'h12, 8'h34, 8'h80, 8'h00, 8'h7F, 8'hFF};
        rv[1].ex = 16'h7FFF;
        rv[1].ey = 16'h8000;
        rv[1].ez = 16'h1234;
        rv[2].rdy = 2;
        rv[2].rx = {8'hBE, 8'hEF, 8'h00, 8'h01, 8'h55, 8'hAA};
        rv[2].ex = 16'h55AA;
        rv[2].ey = 16'h0001;
        rv[2].ez = 16'hBEEF;

        // Reset values.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_op", 32'(cmd_op), 32'd0);
        chk("rst_cmd_data", 32'(cmd_data), 32'd0);
        chk("rst_cmd_nack", 32'(cmd_nack), 32'd0);
        chk("rst_accel_x", 32'(accel_x), 32'd0);
        chk("rst_accel_y", 32'(accel_y), 32'd0);
        chk("rst_accel_z", 32'(accel_z), 32'd0);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);

        // Clean init sequence.
        for (int k = 0; k < 8; k++) push_write(k);
        a0 = e_acc;
        reset = 1'b1;
        for (int i = 0; i < 3000 && init_done !== 1'b1; i++) @(negedge clk);
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_err", 32'(err), 32'd0);
        chk("init_sb_left", 32'(sb_q.size()), 32'd0);
        chk("init_accepts", 32'(e_acc - a0), 32'd40);
        chk("init_state_wait", 32'(state_dbg), 32'd5);

        // Sample reads from the vector table.
        for (int v = 0; v < 3; v++) begin
            rdy_delay = rv[v].rdy;
            push_read();
            for (int b = 0; b < 6; b++) rx_q.push_back(rv[v].rx[b]);
            s0 = sv_cnt;
            for (int i = 0; i < 3000 && sample_valid !== 1'b1; i++)
                @(negedge clk);
            chk($sformatf("v%0d_sv", v), 32'(sample_valid), 32'd1);
            chk($sformatf("v%0d_x", v), 32'(accel_x), 32'(rv[v].ex));
            chk($sformatf("v%0d_y", v), 32'(accel_y), 32'(rv[v].ey));
            chk($sformatf("v%0d_z", v), 32'(accel_z), 32'(rv[v].ez));
            @(negedge clk);
            chk($sformatf("v%0d_sv_low", v), 32'(sample_valid), 32'd0);
            chk($sformatf("v%0d_sv_pulses", v), 32'(sv_cnt - s0), 32'd1);
            chk($sformatf("v%0d_sb_left", v), 32'(sb_q.size()), 32'd0);
        end
        chk("poll_wait_len", 32'(last_wait), 32'(POLL));

        // Reset while byte 4 of the next read is in flight.
        sb_en = 0;
        rdy_delay = 0;
        r0 = e_rd;
        for (int i = 0; i < 3000 && e_rd < r0 + 4; i++) @(negedge clk);
        chk("rd4_reached", 32'(e_rd - r0), 32'd4);
        s0 = sv_cnt;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_accel_x", 32'(accel_x), 32'd0);
        chk("midrst_accel_y", 32'(accel_y), 32'd0);
        chk("midrst_accel_z", 32'(accel_z), 32'd0);
        chk("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("midrst_init_done", 32'(init_done), 32'd0);

        // Restart from init write 0 with one NACK on write 3's address.
        sb_q.delete();
        rx_q.delete();
        a0 = e_acc;
        nack_on = a0 + 16;
        for (int k = 0; k < 3; k++) push_write(k);
        push_cmd(2'b00, 8'h00, 1'b0);
        push_cmd(2'b10, 8'hA6, 1'b0);
        push_cmd(2'b01, 8'h00, 1'b0);
        for (int k = 3; k < 8; k++) push_write(k);
        sb_en = 1;
        reset = 1'b1;
        for (int i = 0; i < 3000 && init_done !== 1'b1; i++) @(negedge clk);
        sb_en = 0;
        nack_on = -1;
        chk("nack1_init_done", 32'(init_done), 32'd1);
        chk("nack1_err", 32'(err), 32'd0);
        chk("nack1_sb_left", 32'(sb_q.size()), 32'd0);
        chk("nack1_accepts", 32'(e_acc - a0), 32'd43);
        chk("nack1_no_sv", 32'(sv_cnt - s0), 32'd0);

        // Permanent NACK: three attempts, then fatal.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        sb_q.delete();
        a0 = e_acc;
        nack_all = 1;
        for (int k = 0; k < MAXR; k++) begin
            push_cmd(2'b00, 8'h00, 1'b0);
            push_cmd(2'b10, 8'hA6, 1'b0);
            push_cmd(2'b01, 8'h00, 1'b0);
        end
        sb_en = 1;
        reset = 1'b1;
        for (int i = 0; i < 1000 && err !== 1'b1; i++) @(negedge clk);
        chk("fatal_err", 32'(err), 32'd1);
        cv = 0;
        repeat (60) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0) cv = 1;
        end
        chk("fatal_quiet", 32'(cv), 32'd0);
        chk("fatal_accepts", 32'(e_acc - a0), 32'(3 * MAXR));
        chk("fatal_sb_left", 32'(sb_q.size()), 32'd0);
        chk("fatal_state", 32'(state_dbg), 32'd15);
        chk("fatal_err_hold", 32'(err), 32'd1);
        chk("fatal_init_done", 32'(init_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
